muldiv_sequencer: RTL and testbench

- Control FSM that sequences the shared mult and div units and commits their results into HI/LO.
- Sits between the main control unit and the mult/div datapath.
- The main control unit issues a one-cycle start with an op select, then stalls on busy until done or an exception pulse.
- Drives MultCtrl, DivCtrl, the HI/LO source-select mux and WriteHILO, so the main FSM no longer hand-sequences multi-cycle arithmetic.

---
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake and control bundle between the main control unit, the mult/div units and
// the HI/LO sequencer.
interface muldiv_sequencer_if;
    logic start;
    logic op;
    logic mult_end;
    logic div_end;
    logic div_zero;
    logic MultCtrl;
    logic DivCtrl;
    logic HILOCtrl;
    logic WriteHILO;
    logic busy;
    logic done;
    logic div_zero_exc;
    logic timeout_exc;

    modport master (
        output start, op, mult_end, div_end, div_zero,
        input  MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, div_zero_exc, timeout_exc
    );

    modport slave (
        input  start, op, mult_end, div_end, div_zero,
        output MultCtrl, DivCtrl, HILOCtrl, WriteHILO, busy, done, div_zero_exc, timeout_exc
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the shared mult/div units and commits results into HI/LO.
// Optional run-state watchdog enabled by defining MULDIV_WDOG_EN.
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StMultRun,
        StDivRun,
        StWrite,
        StDone,
        StDzExc,
        StToExc
    } state_e;

    state_e r_state, w_state_next;
    logic   r_op, w_op_next;
    logic   w_limit;

    logic r_mult_ctrl, r_div_ctrl, r_hilo_ctrl, r_write_hilo, r_busy, r_done, r_dz_exc;
    logic w_mult_ctrl, w_div_ctrl, w_hilo_ctrl, w_write_hilo, w_busy, w_done, w_dz_exc;

    if ((TIMEOUT_CYCLES == 0) || ((2 ** CNT_W) <= TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef MULDIV_WDOG_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_timeout_exc;

    // Counter sits at zero while idle, so an accepted start always begins a run at 0.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == StIdle) begin
            w_cnt_next = '0;
        end else if ((r_state == StMultRun || r_state == StDivRun) && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    assign w_limit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_timeout_exc <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_timeout_exc <= (w_state_next == StToExc);
        end
    end

    assign bus.timeout_exc = r_timeout_exc;
`else
    assign w_limit         = 1'b0;
    assign bus.timeout_exc = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_op_next    = bus.op;
                    w_state_next = bus.op ? StDivRun : StMultRun;
                end
            end
            StMultRun: begin
                if (bus.mult_end) begin
                    w_state_next = StWrite;
                end else if (w_limit) begin
                    w_state_next = StToExc;
                end
            end
            StDivRun: begin
                // div_zero outranks a simultaneous div_end so nothing is committed.
                if (bus.div_zero) begin
                    w_state_next = StDzExc;
                end else if (bus.div_end) begin
                    w_state_next = StWrite;
                end else if (w_limit) begin
                    w_state_next = StToExc;
                end
            end
            StWrite: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            StDzExc: w_state_next = StIdle;
            StToExc: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_mult_ctrl  = 1'b0;
        w_div_ctrl   = 1'b0;
        w_hilo_ctrl  = 1'b0;
        w_write_hilo = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_dz_exc     = 1'b0;
        case (w_state_next)
            StMultRun: begin
                w_mult_ctrl = 1'b1;
                w_busy      = 1'b1;
            end
            StDivRun: begin
                w_div_ctrl  = 1'b1;
                w_hilo_ctrl = 1'b1;
                w_busy      = 1'b1;
            end
            StWrite: begin
                w_write_hilo = 1'b1;
                w_hilo_ctrl  = w_op_next;
                w_busy       = 1'b1;
            end
            StDone: begin
                w_done      = 1'b1;
                w_hilo_ctrl = w_op_next;
                w_busy      = 1'b1;
            end
            StDzExc: begin
                w_dz_exc    = 1'b1;
                w_hilo_ctrl = w_op_next;
                w_busy      = 1'b1;
            end
            StToExc: begin
                w_hilo_ctrl = w_op_next;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_op         <= 1'b0;
            r_mult_ctrl  <= 1'b0;
            r_div_ctrl   <= 1'b0;
            r_hilo_ctrl  <= 1'b0;
            r_write_hilo <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dz_exc     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_mult_ctrl  <= w_mult_ctrl;
            r_div_ctrl   <= w_div_ctrl;
            r_hilo_ctrl  <= w_hilo_ctrl;
            r_write_hilo <= w_write_hilo;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_dz_exc     <= w_dz_exc;
        end
    end

    assign bus.MultCtrl     = r_mult_ctrl;
    assign bus.DivCtrl      = r_div_ctrl;
    assign bus.HILOCtrl     = r_hilo_ctrl;
    assign bus.WriteHILO    = r_write_hilo;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.div_zero_exc = r_dz_exc;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver predicts each transaction's outcome,
// the monitor matches every done/exception pulse against it.
module tb_muldiv_sequencer;
    localparam int unsigned TO_CYC = 8;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(
        .TIMEOUT_CYCLES(TO_CYC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = done, 1 = div-by-zero exception, 2 = watchdog timeout
    typedef struct {
        int kind;
        bit op;
        int pulse;
        int run;
        int busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic void check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor
    initial begin
        exp_t       e;
        int         kind;
        int         mult_cnt, div_cnt, busy_cnt, write_cnt, write_hilo;
        bit         rst_seen;
        logic [7:0] outs;
        mult_cnt = 0; div_cnt = 0; busy_cnt = 0; write_cnt = 0; write_hilo = 0;
        rst_seen = 1'b0;
        forever begin
            @(negedge clk);
            outs = {bus.MultCtrl, bus.DivCtrl, bus.HILOCtrl, bus.WriteHILO,
                    bus.busy, bus.done, bus.div_zero_exc, bus.timeout_exc};
            if (rst_seen) begin
                check("reset_outputs", int'(outs), 0);
                mult_cnt = 0; div_cnt = 0; busy_cnt = 0; write_cnt = 0;
            end else begin
                if (bus.MultCtrl === 1'b1) mult_cnt++;
                if (bus.DivCtrl === 1'b1) div_cnt++;
                if (bus.busy === 1'b1) busy_cnt++;
                if (bus.WriteHILO === 1'b1) begin
                    write_cnt++;
                    write_hilo = int'(bus.HILOCtrl);
                end
                if (bus.busy === 1'b0) check("idle_outputs", int'(outs), 0);
                if (bus.done === 1'b1 || bus.div_zero_exc === 1'b1 || bus.timeout_exc === 1'b1) begin
                    kind = (bus.done === 1'b1) ? 0 : (bus.div_zero_exc === 1'b1) ? 1 : 2;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none",
                                 kind, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_onehot", int'(bus.done) + int'(bus.div_zero_exc)
                              + int'(bus.timeout_exc), 1);
                        check("outcome_kind", kind, e.kind);
                        check("pulse_cycle", cyc, e.pulse);
                        check("mult_cycles", mult_cnt, e.op ? 0 : e.run);
                        check("div_cycles", div_cnt, e.op ? e.run : 0);
                        check("busy_cycles", busy_cnt, e.busy_len);
                        check("hilo_writes", write_cnt, (e.kind == 0) ? 1 : 0);
                        if (e.kind == 0) check("write_hilo_sel", write_hilo, int'(e.op));
                    end
                    mult_cnt = 0; div_cnt = 0; busy_cnt = 0; write_cnt = 0;
                end
            end
            rst_seen = (reset === 1'b1);
        end
    end

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.op       = 1'b0;
        bus.mult_end = 1'b0;
        bus.div_end  = 1'b0;
        bus.div_zero = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d outcomes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // One transaction: start, then the completion flag(s) sampled `delay` edges after accept.
    task automatic run_txn(input bit op, input int delay, input bit use_dz, input bit use_end,
                           input bit noise, input bit extra_start, input bit dead_start);
        exp_t e;
        int   t;
        bit   timed_out;
        bus.start = 1'b1;
        bus.op    = op;
        tick();
        t         = cyc;
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
`ifdef MULDIV_WDOG_EN
        timed_out = (delay > int'(TO_CYC));
`else
        timed_out = 1'b0;
`endif
        e.op = op;
        if (timed_out) begin
            e.kind  = 2;
            e.pulse = t + int'(TO_CYC);
            e.run   = int'(TO_CYC);
        end else if (op && use_dz) begin
            e.kind  = 1;
            e.pulse = t + delay;
            e.run   = delay;
        end else begin
            e.kind  = 0;
            e.pulse = t + delay + 1;
            e.run   = delay;
        end
        e.busy_len = e.pulse - t + 1;
        exp_q.push_back(e);
        // The other unit's flags must be ignored for the whole run.
        if (op) bus.mult_end = noise;
        else begin
            bus.div_end  = noise;
            bus.div_zero = noise;
        end
        for (int i = 0; i < delay - 1; i++) begin
            bus.start = extra_start && (i == 0);
            bus.op    = 1'($urandom);
            tick();
        end
        bus.start = 1'b0;
        if (op) begin
            bus.div_zero = use_dz;
            bus.div_end  = use_end;
        end else begin
            bus.mult_end = 1'b1;
        end
        tick();
        clear_inputs();
        // A start landing on the DONE->IDLE edge must not be taken.
        if (dead_start && e.kind == 0) begin
            tick();
            bus.start = 1'b1;
            bus.op    = 1'($urandom);
            tick();
            bus.start = 1'b0;
        end
        drain();
    endtask

    task automatic reset_mid_run();
        bus.start = 1'b1;
        bus.op    = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mult_end = 1'b1;
        tick();
        bus.mult_end = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        bit op;
        int delay, sel;
        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        run_txn(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        reset_mid_run();
        run_txn(1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_txn(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef MULDIV_WDOG_EN
        run_txn(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            op    = 1'($urandom);
            delay = $urandom_range(1, 12);
            sel   = $urandom_range(1, 3);
            run_txn(op, delay, sel[1], sel[0], 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (3) tick();
        check("final_idle", int'(bus.busy), 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
